// File: rtl/mkio_bus_switch_pkg.sv
// Shared types and sizing helpers for the MKIO redundant-bus switch.
package mkio_bus_switch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RX_LOCK = 2'd1,
    ST_TX      = 2'd2,
    ST_TAIL    = 2'd3
  } state_t;

  localparam int N_CH_MAX = 8;

  // Width of a counter that must hold 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mkio_bus_switch_line_sync.sv
// Two-flop synchroniser for one bus channel's receiver pair, plus the
// enable-masked activity flag.
module mkio_bus_switch_line_sync (
  input  logic clk,
  input  logic di1,
  input  logic di0,
  input  logic en,
  output logic di1_s,
  output logic di0_s,
  output logic active
);

  logic di1_m;
  logic di0_m;

  // Metastability chain only; cleared implicitly once the lines go quiet.
  always_ff @(posedge clk) begin
    di1_m <= di1;
    di0_m <= di0;
    di1_s <= di1_m;
    di0_s <= di0_m;
  end

  assign active = en & (di1_s | di0_s);

endmodule

// File: rtl/mkio_bus_switch.sv
// N-channel MKIO redundant-bus front end: locks onto the channel carrying
// the incoming word, replies on that channel only, then blanks the receiver.
//
// state      | meaning
// IDLE       | no channel locked; waiting for activity or a reply request
// RX_LOCK    | receiving on lock_ch; silence and override timers running
// TX         | core stream routed to lock_ch's transmitter
// TAIL       | post-transmit blanking, all receivers and transmitters off
module mkio_bus_switch
  import mkio_bus_switch_pkg::*;
#(
  parameter  int N_CH        = 2,
  parameter  int SILENCE_CYC = 64,
  parameter  int SWITCH_CYC  = 24,
  parameter  int TAIL_CYC    = 5,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] ch_en,
  input  logic [N_CH-1:0] di1,
  input  logic [N_CH-1:0] di0,
  output logic [N_CH-1:0] do1,
  output logic [N_CH-1:0] do0,
  output logic [N_CH-1:0] rx_strob,
  output logic [N_CH-1:0] tx_inhibit,
  output logic            di1_core,
  output logic            di0_core,
  input  logic            do1_core,
  input  logic            do0_core,
  input  logic            tx_busy,
  output logic            locked,
  output logic [CH_W-1:0] lock_ch,
  output logic [N_CH-1:0] activity,
  output logic            switch_evt,
  output logic            tx_err
);

  localparam int SIL_W = cnt_w(SILENCE_CYC);
  localparam int SW_W  = cnt_w(SWITCH_CYC);
  localparam int TL_W  = cnt_w(TAIL_CYC);

  state_t            state;
  logic [N_CH-1:0]   di1_s;
  logic [N_CH-1:0]   di0_s;
  logic [N_CH-1:0]   act;
  logic [N_CH-1:0]   ch_en_q;
  logic [N_CH-1:0]   lock_mask;
  logic [SIL_W-1:0]  sil_cnt;
  logic [SW_W-1:0]   ovr_cnt [N_CH];
  logic [TL_W-1:0]   tail_cnt;
  logic              busy_q;
  logic              lock_en;
  logic              any_act;
  logic [CH_W-1:0]   low_act;
  logic              sw_hit;
  logic [CH_W-1:0]   sw_ch;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    mkio_bus_switch_line_sync u_sync (
      .clk    (clk),
      .di1    (di1[g]),
      .di0    (di0[g]),
      .en     (ch_en[g]),
      .di1_s  (di1_s[g]),
      .di0_s  (di0_s[g]),
      .active (act[g])
    );
  end

  assign lock_en   = ch_en[lock_ch];
  assign lock_mask = N_CH'(1) << lock_ch;

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    any_act = |act;
    low_act = '0;
    sw_hit  = 1'b0;
    sw_ch   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (act[i]) low_act = CH_W'(i);
      if (act[i] && (CH_W'(i) != lock_ch) && (ovr_cnt[i] == SW_W'(SWITCH_CYC - 1))) begin
        sw_hit = 1'b1;
        sw_ch  = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      lock_ch    <= '0;
      sil_cnt    <= '0;
      tail_cnt   <= '0;
      for (int i = 0; i < N_CH; i++) ovr_cnt[i] <= '0;
      busy_q     <= 1'b0;
      ch_en_q    <= ch_en;
      do1        <= '0;
      do0        <= '0;
      switch_evt <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      busy_q     <= tx_busy;
      ch_en_q    <= ch_en;
      do1        <= '0;
      do0        <= '0;
      switch_evt <= 1'b0;
      tx_err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_busy && !busy_q) begin
            if (lock_en) state <= ST_TX;
            else         tx_err <= 1'b1;
          end else if (any_act) begin
            state   <= ST_RX_LOCK;
            lock_ch <= low_act;
            sil_cnt <= '0;
            for (int i = 0; i < N_CH; i++) ovr_cnt[i] <= '0;
          end
        end
        ST_RX_LOCK: begin
          if (!lock_en) begin
            state <= ST_IDLE;
          end else if (tx_busy) begin
            state <= ST_TX;
          end else if (sw_hit) begin
            lock_ch    <= sw_ch;
            switch_evt <= 1'b1;
            sil_cnt    <= '0;
            for (int i = 0; i < N_CH; i++) ovr_cnt[i] <= '0;
          end else begin
            for (int i = 0; i < N_CH; i++) begin
              if (act[i] && (CH_W'(i) != lock_ch)) begin
                if (ovr_cnt[i] != SW_W'(SWITCH_CYC - 1)) ovr_cnt[i] <= ovr_cnt[i] + 1'b1;
              end else begin
                ovr_cnt[i] <= '0;
              end
            end
            if (act[lock_ch])                            sil_cnt <= '0;
            else if (sil_cnt == SIL_W'(SILENCE_CYC - 1)) state   <= ST_IDLE;
            else                                         sil_cnt <= sil_cnt + 1'b1;
          end
        end
        ST_TX: begin
          // Losing the channel enable drops the drive on the same edge.
          if (!lock_en || !tx_busy) begin
            state    <= ST_TAIL;
            tail_cnt <= '0;
          end else begin
            do1 <= lock_mask & {N_CH{do1_core}};
            do0 <= lock_mask & {N_CH{do0_core}};
          end
        end
        ST_TAIL: begin
          if (tx_busy && lock_en)                     state    <= ST_TX;
          else if (tail_cnt == TL_W'(TAIL_CYC - 1))   state    <= ST_IDLE;
          else                                        tail_cnt <= tail_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign locked     = (state != ST_IDLE);
  assign rx_strob   = (state == ST_TX || state == ST_TAIL) ? '0 : ch_en_q;
  assign tx_inhibit = (state == ST_TX) ? ~lock_mask : '1;
  assign di1_core   = (state == ST_RX_LOCK) && di1_s[lock_ch];
  assign di0_core   = (state == ST_RX_LOCK) && di0_s[lock_ch];
  assign activity   = act;

endmodule

// File: tb/tb_mkio_bus_switch.sv
// Directed bench for mkio_bus_switch (4 channels) with a timestamp-based
// reference model checked every cycle.
`timescale 1ns/1ps
module tb_mkio_bus_switch;

  localparam int NCH = 4;
  localparam int SIL = 64;
  localparam int SW  = 24;
  localparam int TL  = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ch_en, di1, di0, do1, do0, rx_strob, tx_inhibit, activity;
  logic       di1_core, di0_core, do1_core, do0_core, tx_busy;
  logic       locked, switch_evt, tx_err;
  logic [1:0] lock_ch;

  always #5 clk = ~clk;

  mkio_bus_switch #(.N_CH(NCH), .SILENCE_CYC(SIL), .SWITCH_CYC(SW), .TAIL_CYC(TL)) dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .di1(di1), .di0(di0), .do1(do1), .do0(do0),
    .rx_strob(rx_strob), .tx_inhibit(tx_inhibit), .di1_core(di1_core), .di0_core(di0_core),
    .do1_core(do1_core), .do0_core(do0_core), .tx_busy(tx_busy), .locked(locked),
    .lock_ch(lock_ch), .activity(activity), .switch_evt(switch_evt), .tx_err(tx_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 2;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference model: line history plus timestamps of the last lock-channel
  // activity, the start of each competing run and the start of the tail.
  typedef enum {M_IDLE, M_RX, M_TX, M_TAIL} mode_t;
  mode_t      m_mode = M_IDLE;
  int         m_lock = 0, m_last = 0, m_tail_start = 0;
  int         m_run [NCH];
  bit         m_prev_busy = 1'b0, m_valid = 1'b0;
  logic [3:0] h1 [1024];
  logic [3:0] h0 [1024];
  logic       e_locked, e_sw, e_err, e_c1, e_c0;
  logic [3:0] e_do1, e_do0, e_rxs, e_inh, e_act, en, act, s1, s0;
  int         win, u;

  initial for (int i = 0; i < 1024; i++) begin h1[i] = '0; h0[i] = '0; end

  always @(posedge clk) begin
    u = cyc;
    h1[u % 1024] = di1;
    h0[u % 1024] = di0;
    s1 = h1[(u - 2) % 1024];
    s0 = h0[(u - 2) % 1024];
    en = ch_en;
    act = (s1 | s0) & en;
    e_sw = 1'b0; e_err = 1'b0; e_do1 = '0; e_do0 = '0;
    if (reset) begin
      m_mode = M_IDLE; m_lock = 0; m_prev_busy = 1'b0; m_valid = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (tx_busy && !m_prev_busy) begin
            if (en[m_lock]) m_mode = M_TX; else e_err = 1'b1;
          end else if (act != 0) begin
            m_mode = M_RX; m_last = u;
            for (int i = NCH - 1; i >= 0; i--) if (act[i]) m_lock = i;
            for (int i = 0; i < NCH; i++) m_run[i] = -1;
          end
        end
        M_RX: begin
          if (!en[m_lock]) m_mode = M_IDLE;
          else if (tx_busy) m_mode = M_TX;
          else begin
            win = -1;
            for (int i = 0; i < NCH; i++) begin
              if (i != m_lock && act[i]) begin
                if (m_run[i] < 0) m_run[i] = u;
                if (u - m_run[i] + 1 == SW && win < 0) win = i;
              end else m_run[i] = -1;
            end
            if (win >= 0) begin
              m_lock = win; e_sw = 1'b1; m_last = u;
              for (int i = 0; i < NCH; i++) m_run[i] = -1;
            end else if (act[m_lock]) m_last = u;
            else if (u - m_last == SIL) m_mode = M_IDLE;
          end
        end
        M_TX: begin
          if (!en[m_lock] || !tx_busy) begin m_mode = M_TAIL; m_tail_start = u + 1; end
          else begin e_do1[m_lock] = do1_core; e_do0[m_lock] = do0_core; end
        end
        M_TAIL: begin
          if (tx_busy && en[m_lock]) m_mode = M_TX;
          else if (u + 1 - m_tail_start == TL) m_mode = M_IDLE;
        end
      endcase
      m_prev_busy = tx_busy;
    end
    e_locked = (m_mode != M_IDLE);
    e_rxs    = (m_mode == M_TX || m_mode == M_TAIL) ? 4'b0 : en;
    e_inh    = (m_mode == M_TX) ? ~(4'b1 << m_lock) : 4'hF;
    e_c1     = (m_mode == M_RX) ? h1[(u - 1) % 1024][m_lock] : 1'b0;
    e_c0     = (m_mode == M_RX) ? h0[(u - 1) % 1024][m_lock] : 1'b0;
    e_act    = (h1[(u - 1) % 1024] | h0[(u - 1) % 1024]) & en;
    cyc++;
    #1;
    if (m_valid) begin
      chk("locked", locked, e_locked);
      chk("lock_ch", lock_ch, m_lock);
      chk("switch_evt", switch_evt, e_sw);
      chk("tx_err", tx_err, e_err);
      chk("do1", do1, e_do1);
      chk("do0", do0, e_do0);
      chk("rx_strob", rx_strob, e_rxs);
      chk("tx_inhibit", tx_inhibit, e_inh);
      chk("di1_core", di1_core, e_c1);
      chk("di0_core", di0_core, e_c0);
      chk("activity", activity, e_act);
    end
  end

  task automatic word(input int ch, input int len);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      di1[ch] = ((k / 4) % 2 == 0);
      di0[ch] = ((k / 4) % 2 != 0);
    end
  endtask

  task automatic tx_burst(input int len);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      tx_busy = 1'b1; do1_core = k[3]; do0_core = ~k[3];
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; ch_en = 4'b0011; di1 = '0; di0 = '0;
    do1_core = 1'b0; do0_core = 1'b0; tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_lock_ch", lock_ch, 0);
    chk("rst_tx_inhibit", tx_inhibit, 4'hF);
    chk("rst_rx_strob", rx_strob, 4'b0011);
    chk("rst_do", {do1, do0}, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Word on ch1 only: lock after 2 sync stages + 1 decision edge.
    di1[1] = 1'b1;
    n = 0; while (!locked && n < 10) begin @(posedge clk); #1; n++; end
    chk("lock_latency", n, 3);
    chk("lock_ch1", lock_ch, 1);
    word(1, 40);
    @(negedge clk); di1 = '0; di0 = '0;
    // 64 idle cycles plus the 2-stage synchroniser delay.
    n = 0; while (locked && n < 100) begin @(posedge clk); #1; n++; end
    chk("unlock_latency", n, 66);

    // Simultaneous ch0/ch1: lowest wins, ch1 then overrides after 24 cycles.
    @(negedge clk); di1 = 4'b0011;
    n = 0; while (!locked && n < 10) begin @(posedge clk); #1; n++; end
    chk("dual_lock_ch", lock_ch, 0);
    n = 0; while (!switch_evt && n < 40) begin @(posedge clk); #1; n++; end
    chk("switch_latency", n, 24);
    chk("switch_lock_ch", lock_ch, 1);
    @(negedge clk); di1 = 4'b0010;
    repeat (10) @(negedge clk);
    di1 = '0;
    n = 0; while (locked && n < 120) begin @(posedge clk); #1; n++; end
    chk("dual_unlocked", locked, 0);

    // Reply on ch1 for 320 cycles, then 5-cycle tail.
    word(1, 12);
    @(negedge clk); di1 = '0; di0 = '0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 320; k++) begin
      @(negedge clk);
      if (k == 100) begin
        chk("tx_rx_strob", rx_strob, 4'b0000);
        chk("tx_inhibit_ch1", tx_inhibit, 4'b1101);
        chk("tx_do_k99", {do1, do0}, 8'b0000_0010);
      end
      tx_busy = 1'b1; do1_core = k[3]; do0_core = ~k[3];
    end
    @(negedge clk); tx_busy = 1'b0; do1_core = 1'b0; do0_core = 1'b0;
    n = 0; while (rx_strob == 4'b0000 && n < 20) begin @(posedge clk); #1; n++; end
    chk("tail_len", n, 6);
    chk("tail_rx_strob", rx_strob, 4'b0011);

    // Re-assert during the tail resumes TX on the same channel.
    tx_burst(20);
    @(negedge clk); tx_busy = 1'b0;
    @(negedge clk);
    @(negedge clk); tx_busy = 1'b1;
    @(negedge clk);
    chk("tail_reenter_inh", tx_inhibit, 4'b1101);
    tx_burst(10);
    @(negedge clk); tx_busy = 1'b0;
    repeat (10) @(negedge clk);

    // ch1 disabled: no lock, and a reply request on ch1 is refused.
    ch_en = 4'b0001;
    word(1, 10);
    @(negedge clk);
    chk("masked_locked", locked, 0);
    chk("masked_activity", activity, 4'b0000);
    di1 = '0; di0 = '0;
    repeat (3) @(negedge clk);
    tx_busy = 1'b1;
    n = 0; while (!tx_err && n < 5) begin @(posedge clk); #1; n++; end
    chk("tx_err_latency", n, 1);
    chk("tx_err_do", {do1, do0}, 8'h00);
    repeat (5) @(negedge clk);
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);

    // Enable dropped mid-TX: drive cut, 5-cycle tail, back to idle.
    ch_en = 4'b0011;
    word(1, 8);
    @(negedge clk); di1 = '0; di0 = '0;
    tx_burst(30);
    @(negedge clk); ch_en = 4'b0001;
    n = 0; while (locked && n < 20) begin @(posedge clk); #1; n++; end
    chk("en_drop_unlock", n, 6);
    @(negedge clk); tx_busy = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a reply on ch3.
    ch_en = 4'hF;
    word(3, 8);
    @(negedge clk); di1 = '0; di0 = '0;
    chk("ch3_lock", lock_ch, 3);
    tx_burst(20);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("rst_tx_do", {do1, do0}, 8'h00);
    chk("rst_tx_inhibit_all", tx_inhibit, 4'hF);
    chk("rst_tx_locked", locked, 0);
    chk("rst_tx_lock_ch", lock_ch, 0);
    tx_busy = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
